mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
- Initiator side of the multiply/divide unit (MDU) Start/Busy protocol. Sits between the E-stage pipeline and the MDU.
- Accepts MDU operations from the pipeline on a valid/ready interface and buffers up to DEPTH of them.
- Issues each operation to the MDU only when it is idle, tracks Busy rise and fall, and returns mfhi/mflo read data on a response port.
- Drives a pending flag that the hazard unit uses to stall later MDU-dependent instructions.

Parameters:
- DEPTH, 2, request buffer entries (power of two, 2..4).
- TIMEOUT, 16, maximum cycles allowed in WAIT_FALL before err is set.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents an operation
- req_ready  out  1  buffer can accept this cycle
- req_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- resp_valid  out  1  one-cycle pulse carrying mfhi/mflo data
- resp_data  out  32  read data
- pending  out  1  buffer non-empty or operation in flight
- err  out  1  sticky timeout flag
- mdu_ctrl  out  4  operation code driven to the MDU
- mdu_d1  out  32  operand A to the MDU
- mdu_d2  out  32  operand B to the MDU
- mdu_start  out  1  start strobe for mult/multu/div/divu
- mdu_busy  in  1  MDU busy
- mdu_out  in  32  MDU read data, combinational on mdu_ctrl

Behaviour:
- Reset: FIFO empty, state IDLE, all outputs 0 except req_ready=1. The MDU shares this reset.
- Push:
  - Occurs when req_valid && req_ready && req_op in 1..8.
  - req_op 0 or 9..15 is silently dropped.
  - req_ready = (count != DEPTH), from registered count only.
  - Push and pop in the same cycle keeps count unchanged.
- Default drive: mdu_ctrl, mdu_d1, mdu_d2 and mdu_start are 0 every cycle except the single issue cycle. A nonzero mdu_ctrl held while the MDU is idle would be re-latched by it.
- FSM states are IDLE, WAIT_RISE and WAIT_FALL.
- IDLE, when FIFO non-empty and mdu_busy==0: issue the head combinationally this cycle (mdu_ctrl=op, mdu_d1=a, mdu_d2=b) and pop it.
  - mult/multu/div/divu: mdu_start=1, next state WAIT_RISE.
  - mthi/mtlo: no start; the MDU writes HI/LO at this edge; stay IDLE.
  - mfhi/mflo: register mdu_out into resp_data; resp_valid=1 next cycle; stay IDLE.
  - Back-to-back IDLE issues are allowed, one per cycle.
- IDLE with mdu_busy==1 (not caused by this block): hold, no issue.
- WAIT_RISE: mdu_busy==1 moves to WAIT_FALL. mdu_busy==0 for one cycle sets err and returns to IDLE.
- WAIT_FALL:
  - A wait counter increments each cycle.
  - mdu_busy==0 moves to IDLE and clears the counter; HI/LO are valid from this cycle.
  - counter==TIMEOUT-1 sets err and forces IDLE.
- pending = (count!=0) || (state!=IDLE), combinational.
- Ordering: strict FIFO. mfhi/mflo never overtake an earlier mult/div, so a read always observes the completed result.
- resp_valid is exactly one cycle per mfhi/mflo and is 0 otherwise. resp_data holds its last value between pulses.
- err is cleared only by reset.
- Reset mid-operation: FSM goes to IDLE, FIFO flushes, and no response is emitted for dropped mf ops.

Test Plan:
- Push mult a=3, b=0xFFFFFFFE, then mflo -> mdu_start pulses once. mflo is issued only after mdu_busy falls. resp_valid pulses once with resp_data=0xFFFFFFFA. A following mfhi returns 0xFFFFFFFF.
- Push div 7,2 then mfhi, mflo back-to-back -> responses 1 then 3 on consecutive resp_valid pulses. pending deasserts the cycle after the last issue.
- mthi 0x12345678 then mfhi, with MDU idle -> issued on consecutive cycles; resp_data=0x12345678 two cycles after the mthi issue.
- Fill the FIFO with DEPTH mult ops while the MDU is busy -> req_ready=0 when count=DEPTH. A push attempted while req_ready=0 is not accepted. Ops issue in order, each waiting for Busy to fall.
- Hold mdu_busy=1 after start for TIMEOUT cycles -> err=1 sticky and state returns to IDLE.
- Assert reset during WAIT_FALL with 2 queued ops -> next cycle pending=0, req_ready=1, no resp_valid, mdu_ctrl=0.

Source files
------------

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline request/response and MDU Start/Busy signals of the MDU issue controller.
// slave is the controller's view; master is the environment's (pipeline + MDU).
interface mdu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        pending;
    logic        err;
    logic [3:0]  mdu_ctrl;
    logic [31:0] mdu_d1;
    logic [31:0] mdu_d2;
    logic        mdu_start;
    logic        mdu_busy;
    logic [31:0] mdu_out;

    modport slave (
        input  req_valid, req_op, req_a, req_b, mdu_busy, mdu_out,
        output req_ready, resp_valid, resp_data, pending, err,
               mdu_ctrl, mdu_d1, mdu_d2, mdu_start
    );

    modport master (
        output req_valid, req_op, req_a, req_b, mdu_busy, mdu_out,
        input  req_ready, resp_valid, resp_data, pending, err,
               mdu_ctrl, mdu_d1, mdu_d2, mdu_start
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Initiator side of the MDU Start/Busy protocol: buffers pipeline MDU ops in a FIFO,
// issues them one at a time while the MDU is idle, and returns mfhi/mflo data.
module mdu_issue_ctrl #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input logic          clk,
    input logic          reset,
    mdu_issue_ctrl_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;

    logic [3:0]         op_mem [DEPTH];
    logic [31:0]        a_mem  [DEPTH];
    logic [31:0]        b_mem  [DEPTH];

    logic               push, pop, issue;
    logic               req_ready;
    logic [3:0]         head_op;
    logic [31:0]        head_a, head_b;
    logic               head_is_start, head_is_mf;
    logic [3:0]         mdu_ctrl;
    logic [31:0]        mdu_d1, mdu_d2;
    logic               mdu_start;

    assign head_op       = op_mem[rd_ptr_q];
    assign head_a        = a_mem[rd_ptr_q];
    assign head_b        = b_mem[rd_ptr_q];
    assign head_is_start = (head_op >= 4'd1) && (head_op <= 4'd4);
    assign head_is_mf    = (head_op == 4'd7) || (head_op == 4'd8);

    assign req_ready = (count_q != CNT_W'(DEPTH));
    assign push      = bus.req_valid && req_ready && (bus.req_op >= 4'd1) && (bus.req_op <= 4'd8);
    // Only issue from IDLE into an idle MDU; a busy MDU in IDLE belongs to someone else.
    assign issue     = (state_q == IDLE) && (count_q != '0) && !bus.mdu_busy && !reset;
    assign pop       = issue;

    // FIFO pointer/count bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= bus.req_op;
            a_mem[wr_ptr_q]  <= bus.req_a;
            b_mem[wr_ptr_q]  <= bus.req_b;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (issue && head_is_start) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                wait_cnt_d = '0;
                if (bus.mdu_busy) begin
                    state_d = WAIT_FALL;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!bus.mdu_busy) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the MDU bus is zero except on the single issue cycle
    always_comb begin
        mdu_ctrl     = '0;
        mdu_d1       = '0;
        mdu_d2       = '0;
        mdu_start    = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        if (issue) begin
            mdu_ctrl  = head_op;
            mdu_d1    = head_a;
            mdu_d2    = head_b;
            mdu_start = head_is_start;
            if (head_is_mf) begin
                resp_valid_d = 1'b1;
                resp_data_d  = bus.mdu_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.pending    = (count_q != '0) || (state_q != IDLE);
    assign bus.err        = err_q;
    assign bus.mdu_ctrl   = mdu_ctrl;
    assign bus.mdu_d1     = mdu_d1;
    assign bus.mdu_d2     = mdu_d2;
    assign bus.mdu_start  = mdu_start;
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: an MDU responder plus a queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mdu_issue_ctrl;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if ifc ();

    mdu_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    int n_vec, n_err, cyc;

    // MDU responder state
    logic [31:0] env_hi, env_lo;
    int          env_busy_cnt, env_ext_cnt, force_lat;
    bit          ext_en;
    logic [3:0]  e_ctrl;
    logic [31:0] e_d1, e_d2;
    logic        e_start, e_rst;

    assign ifc.mdu_out = (ifc.mdu_ctrl == 4'd7) ? env_hi :
                         (ifc.mdu_ctrl == 4'd8) ? env_lo : 32'd0;

    // Reference model state
    req_t        mq[$];
    bit          m_rv, m_err, m_inflight, m_risen;
    logic [31:0] m_rd;
    logic [63:0] m_hilo;
    int          m_wait;

    // Observation logs for directed checks
    logic [31:0] resp_log[$];
    int          resp_cyc[$];
    int          issue_cyc[$];
    int          start_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Architectural HI/LO effect of one MDU op, returned as {hi, lo}
    function automatic logic [63:0] mdu_exec(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = hilo;
        case (op)
            4'd1: res = 64'(sa * sb);
            4'd2: res = {32'd0, a} * {32'd0, b};
            4'd3: if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                  else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            4'd4: if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                  else res = {a % b, a / b};
            4'd5: res = {a, hilo[31:0]};
            4'd6: res = {hilo[63:32], a};
            default: ;
        endcase
        return res;
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 0;
        if (r == 1) return int'(TIMEOUT);
        if (r == 2) return int'(TIMEOUT) + 1;
        if (r == 3) return int'(TIMEOUT) + 4;
        return int'($urandom_range(1, 5));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rv = 0; m_rd = '0; m_err = 0; m_inflight = 0; m_risen = 0; m_wait = 0; m_hilo = '0;
    endtask

    // Compare DUT against the model for this cycle, then advance the model
    task automatic compare_and_advance();
        bit   busy, rst, exp_ready, exp_pend, can_issue, exp_start;
        req_t head;
        busy      = ifc.mdu_busy;
        rst       = reset;
        exp_ready = (mq.size() < DEPTH);
        exp_pend  = (mq.size() != 0) || m_inflight;
        can_issue = !m_inflight && (mq.size() != 0) && !busy && !rst;
        head.op = 4'd0; head.a = '0; head.b = '0;
        if (can_issue) head = mq[0];
        exp_start = can_issue && (head.op >= 4'd1) && (head.op <= 4'd4);

        chk("req_ready",  ifc.req_ready,  exp_ready);
        chk("pending",    ifc.pending,    exp_pend);
        chk("resp_valid", ifc.resp_valid, m_rv);
        chk("resp_data",  ifc.resp_data,  m_rd);
        chk("err",        ifc.err,        m_err);
        chk("mdu_ctrl",   ifc.mdu_ctrl,   head.op);
        chk("mdu_d1",     ifc.mdu_d1,     head.a);
        chk("mdu_d2",     ifc.mdu_d2,     head.b);
        chk("mdu_start",  ifc.mdu_start,  exp_start);

        if (ifc.resp_valid) begin resp_log.push_back(ifc.resp_data); resp_cyc.push_back(cyc); end
        if (ifc.mdu_start) start_cnt++;
        if (ifc.mdu_ctrl != 4'd0) issue_cyc.push_back(cyc);

        if (rst) begin
            model_reset();
        end else begin
            m_rv = 0;
            if (can_issue) begin
                void'(mq.pop_front());
                if (head.op == 4'd7)      begin m_rv = 1; m_rd = m_hilo[63:32]; end
                else if (head.op == 4'd8) begin m_rv = 1; m_rd = m_hilo[31:0]; end
                else m_hilo = mdu_exec(head.op, head.a, head.b, m_hilo);
                if (exp_start) begin m_inflight = 1; m_risen = 0; m_wait = 0; end
            end else if (m_inflight && !m_risen) begin
                if (busy) m_risen = 1;
                else begin m_err = 1; m_inflight = 0; end
            end else if (m_inflight) begin
                if (!busy) m_inflight = 0;
                else if (m_wait == int'(TIMEOUT) - 1) begin m_err = 1; m_inflight = 0; end
                else m_wait++;
            end
            if (ifc.req_valid && exp_ready && ifc.req_op >= 4'd1 && ifc.req_op <= 4'd8)
                mq.push_back('{op: ifc.req_op, a: ifc.req_a, b: ifc.req_b});
        end
    endtask

    task automatic env_apply();
        if (e_rst) begin
            env_busy_cnt = 0; env_ext_cnt = 0; env_hi = '0; env_lo = '0;
        end else begin
            if (e_ctrl >= 4'd1 && e_ctrl <= 4'd6)
                {env_hi, env_lo} = mdu_exec(e_ctrl, e_d1, e_d2, {env_hi, env_lo});
            if (e_start) env_busy_cnt = (force_lat >= 0) ? force_lat : pick_lat();
            else if (env_busy_cnt > 0) env_busy_cnt--;
            if (env_ext_cnt > 0) env_ext_cnt--;
            else if (ext_en && env_busy_cnt == 0 && $urandom_range(0, 19) == 0)
                env_ext_cnt = int'($urandom_range(1, 3));
        end
        ifc.mdu_busy = (env_busy_cnt != 0) || (env_ext_cnt != 0);
    endtask

    task automatic step();
        @(negedge clk);
        compare_and_advance();
        e_ctrl = ifc.mdu_ctrl; e_d1 = ifc.mdu_d1; e_d2 = ifc.mdu_d2;
        e_start = ifc.mdu_start; e_rst = reset;
        cyc++;
        @(posedge clk);
        #1;
        env_apply();
    endtask

    task automatic idle_in();
        ifc.req_valid = 1'b0; ifc.req_op = 4'd0; ifc.req_a = '0; ifc.req_b = '0;
    endtask

    task automatic push_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_a = a; ifc.req_b = b;
        step();
        idle_in();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!ifc.pending) break;
            step();
        end
        chk(name, ifc.pending, 1'b0);
        step();
        step();
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < resp_log.size()) return resp_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        resp_log.delete(); resp_cyc.delete(); issue_cyc.delete(); start_cnt = 0;
    endtask

    initial begin
        logic [63:0] pin;
        int          r;
        n_vec = 0; n_err = 0; cyc = 0;
        env_hi = '0; env_lo = '0; env_busy_cnt = 0; env_ext_cnt = 0;
        force_lat = -1; ext_en = 0;
        e_ctrl = '0; e_d1 = '0; e_d2 = '0; e_start = 0; e_rst = 1;
        model_reset();
        clear_logs();
        reset = 1'b1;
        ifc.mdu_busy = 1'b0;
        idle_in();
        @(posedge clk);
        #1;

        // Pin the reference arithmetic
        pin = mdu_exec(4'd1, 32'd3, 32'hFFFF_FFFE, 64'd0);
        chk("pin_mult_lo", pin[31:0], 32'hFFFF_FFFA);
        chk("pin_mult_hi", pin[63:32], 32'hFFFF_FFFF);
        pin = mdu_exec(4'd3, 32'd7, 32'd2, 64'd0);
        chk("pin_div_hi", pin[63:32], 32'd1);
        chk("pin_div_lo", pin[31:0], 32'd3);

        step();
        reset = 1'b0;
        chk("rst_ready",   ifc.req_ready,  1'b1);
        chk("rst_pending", ifc.pending,    1'b0);
        chk("rst_resp",    ifc.resp_valid, 1'b0);
        chk("rst_err",     ifc.err,        1'b0);
        chk("rst_ctrl",    ifc.mdu_ctrl,   4'd0);

        // mult then mflo/mfhi
        clear_logs(); force_lat = 3;
        push_op(4'd1, 32'd3, 32'hFFFF_FFFE);
        push_op(4'd8, 32'd0, 32'd0);
        push_op(4'd7, 32'd0, 32'd0);
        drain("t1_drain");
        chk("t1_starts", start_cnt, 1);
        chk("t1_nresp",  resp_log.size(), 2);
        chk("t1_mflo",   log_at(0), 32'hFFFF_FFFA);
        chk("t1_mfhi",   log_at(1), 32'hFFFF_FFFF);

        // div then mfhi, mflo
        clear_logs(); force_lat = 5;
        push_op(4'd3, 32'd7, 32'd2);
        push_op(4'd7, 32'd0, 32'd0);
        push_op(4'd8, 32'd0, 32'd0);
        drain("t2_drain");
        chk("t2_mfhi", log_at(0), 32'd1);
        chk("t2_mflo", log_at(1), 32'd3);
        chk("t2_consecutive", (resp_cyc.size() == 2) ? resp_cyc[1] - resp_cyc[0] : -1, 1);

        // mthi then mfhi with MDU idle
        clear_logs();
        push_op(4'd5, 32'h1234_5678, 32'd0);
        push_op(4'd7, 32'd0, 32'd0);
        drain("t3_drain");
        chk("t3_data", log_at(0), 32'h1234_5678);
        chk("t3_issue_gap", (issue_cyc.size() == 2) ? issue_cyc[1] - issue_cyc[0] : -1, 1);
        chk("t3_resp_lat", (issue_cyc.size() == 2 && resp_cyc.size() == 1) ?
                           resp_cyc[0] - issue_cyc[0] : -1, 2);

        // Fill the FIFO behind an externally busy MDU; one extra push must be refused
        clear_logs(); force_lat = 2;
        env_ext_cnt = 12; ifc.mdu_busy = 1'b1;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            if (i == int'(DEPTH)) chk("t4_full_ready", ifc.req_ready, 1'b0);
            ifc.req_valid = 1'b1; ifc.req_op = 4'd1; ifc.req_a = 32'(i + 1); ifc.req_b = 32'd2;
            step();
        end
        idle_in();
        drain("t4_drain");
        chk("t4_starts", start_cnt, int'(DEPTH));

        // Busy held past the timeout
        clear_logs(); force_lat = int'(TIMEOUT) + 4;
        push_op(4'd1, 32'd5, 32'd6);
        drain("t5_drain");
        chk("t5_err", ifc.err, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (!ifc.mdu_busy) break;
            step();
        end
        push_op(4'd8, 32'd0, 32'd0);
        drain("t5_drain2");
        chk("t5_err_sticky", ifc.err, 1'b1);
        chk("t5_mflo", log_at(0), 32'd30);

        // Reset during WAIT_FALL with two ops queued
        clear_logs(); force_lat = 10;
        push_op(4'd1, 32'd2, 32'd3);
        push_op(4'd8, 32'd0, 32'd0);
        push_op(4'd7, 32'd0, 32'd0);
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_pending", ifc.pending,    1'b0);
        chk("t6_ready",   ifc.req_ready,  1'b1);
        chk("t6_resp",    ifc.resp_valid, 1'b0);
        chk("t6_ctrl",    ifc.mdu_ctrl,   4'd0);
        chk("t6_err",     ifc.err,        1'b0);
        for (int i = 0; i < 8; i++) step();
        chk("t6_no_resp", resp_log.size(), 0);

        // Randomized traffic
        force_lat = -1; ext_en = 1;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            ifc.req_valid = ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 3) ifc.req_op = (r == 0) ? 4'd8 : 4'd7;
            else ifc.req_op = 4'($urandom_range(0, 15));
            ifc.req_a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            ifc.req_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            step();
        end
        reset = 1'b0;
        idle_in();
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
